product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 64: width of the incoming multiplier product.
REQ-002 SHALL have parameter ACC_W, default 72: accumulator width (PROD_W plus 8 guard bits); ACC_W SHALL be >= PROD_W.
REQ-003 SHALL have parameter CNT_W, default 8: width of the product-count field.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 start  input  1  one-cycle request to begin an accumulation; sampled only in IDLE.
REQ-007 len  input  CNT_W  number of products to accumulate; sampled with start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 prod_valid  input  1  upstream multiplier product is valid.
REQ-010 prod_ready  output  1  block accepts a product this cycle.
REQ-011 product  input  PROD_W  unsigned multiplier product.
REQ-012 acc_valid  output  1  accumulated result is valid.
REQ-013 acc_ready  input  1  downstream accepts the result.
REQ-014 acc_out  output  ACC_W  accumulated sum.
REQ-015 overflow  output  1  sticky flag: the sum exceeded 2^ACC_W-1 during the current accumulation.

Function
REQ-016 SHALL implement three states: IDLE, ACCUM, DONE.
REQ-017 In IDLE with start=1 and len>0: clear the accumulator and overflow, load the counter with len, go to ACCUM.
REQ-018 In IDLE with start=1 and len=0: clear the accumulator and overflow, go directly to DONE (result 0).
REQ-019 start SHALL be ignored in ACCUM and DONE.
REQ-020 prod_ready SHALL be 1 only in ACCUM; a transfer occurs when prod_valid and prod_ready are both 1 at a rising edge.
REQ-021 On each transfer: acc <= acc + zero-extended product, computed modulo 2^ACC_W; counter decrements by 1.
REQ-022 A carry out of bit ACC_W-1 on any transfer SHALL set overflow; overflow stays set until the next accepted start or reset.
REQ-023 A transfer with counter=1 SHALL move the block to DONE.
REQ-024 acc_valid SHALL rise in the cycle after the final transfer, giving 1-cycle latency from the last product to the result.
REQ-025 prod_valid=0 in ACCUM SHALL stall the block with no state change; there is no timeout.
REQ-026 In DONE: acc_valid=1; acc_out and overflow SHALL be held stable until acc_ready=1.
REQ-027 On DONE with acc_ready=1: go to IDLE; acc_out keeps its value until the next accepted start.
REQ-028 Sustained throughput in ACCUM SHALL be one product per cycle.
REQ-029 Products presented outside ACCUM SHALL NOT be accepted or summed.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, without waiting for a clock edge.
REQ-031 Reset SHALL clear the accumulator, counter and overflow.
REQ-032 Reset SHALL drive busy=0, prod_ready=0, acc_valid=0, acc_out=0, overflow=0.
REQ-033 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial sum with no result emitted.
REQ-034 After release, the first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-035 start, len=3; products 5, 7, 11 back-to-back -> acc_valid one cycle after third transfer, acc_out=23, overflow=0.
REQ-036 start, len=2; products 0xFFFF_FFFF_FFFF_FFFF twice -> acc_out=0x1_FFFF_FFFF_FFFF_FFFE, overflow=0 (guard bits absorb the carry).
REQ-037 ACC_W=64, len=2; products 2^63 and 2^63 -> acc_out=0, overflow=1; a new start clears overflow to 0.
REQ-038 start, len=0 -> DONE next cycle, acc_out=0, no prod_ready pulse; hold acc_ready=0 for 4 cycles -> acc_valid and acc_out remain stable.
REQ-039 len=4, prod_valid gapped (1,0,0,1,1,0,1) with start pulsed during ACCUM -> exactly 4 products summed, start ignored, busy=1 throughout.
REQ-040 Assert rst_n=0 after 2 of 4 transfers -> outputs zero immediately; after release, start with len=1, product 9 -> acc_out=9.

Source files
------------

// File: rtl/product_accumulator.sv
// Product accumulator: sums a run of `len` unsigned multiplier products into a
// guard-bit-extended accumulator, then presents the result through a
// valid/ready handshake. Overflow is a sticky carry-out flag per accumulation.
module product_accumulator #(
   parameter int unsigned PROD_W = 64,
   parameter int unsigned ACC_W  = 72,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   output logic              busy,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] product,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow
);

   // Zero-extension width so the sum keeps one extra bit for the carry-out.
   localparam int unsigned PadW = ACC_W + 1 - PROD_W;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic [ACC_W:0]     sum;
   logic               xfer;

   // Transfer qualification and widened sum for the running accumulation.
   always_comb begin
      xfer = (state_q == StAccum) && prod_valid;
      sum  = {1'b0, acc_q} + {{PadW{1'b0}}, product};
   end

   // Control FSM and datapath registers; reset discards any partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  acc_q <= '0;
                  ovf_q <= 1'b0;
                  cnt_q <= len;
                  // A zero-length request completes immediately with a zero result.
                  state_q <= (len != '0) ? StAccum : StDone;
               end
            end
            StAccum: begin
               if (xfer) begin
                  acc_q <= sum[ACC_W-1:0];
                  ovf_q <= ovf_q | sum[ACC_W];
                  cnt_q <= cnt_q - CntOne;
                  if (cnt_q == CntOne) begin
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               if (acc_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs decode straight from registered state, so they are glitch-free.
   always_comb begin
      busy       = (state_q != StIdle);
      prod_ready = (state_q == StAccum);
      acc_valid  = (state_q == StDone);
      acc_out    = acc_q;
      overflow   = ovf_q;
   end

endmodule
